l2_bus_miss_engine: RTL and testbench



---
 rtl/l2_bus_miss_engine_pkg.sv | 58 +++++
 rtl/l2_bus_miss_engine_sync_fifo.sv | 72 +++++++
 rtl/l2_bus_miss_engine.sv | 228 ++++++++++++++++++++++
 tb/tb_l2_bus_miss_engine.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_bus_miss_engine_pkg.sv
// Shared L2 types, request encodings and cache-line helpers for the bus miss engine.
package l2_bus_miss_engine_pkg;

  localparam int unsigned CACHE_LINE_BITS  = 512;
  localparam int unsigned BEATS_PER_LINE   = CACHE_LINE_BITS / 32;
  localparam int unsigned LINE_OFFSET_BITS = 6;
  localparam int unsigned LINE_INDEX_BITS  = 32 - LINE_OFFSET_BITS;
  localparam int unsigned SET_INDEX_BITS   = 10;
  localparam int unsigned TAG_BITS         = LINE_INDEX_BITS - SET_INDEX_BITS;

  typedef logic [TAG_BITS-1:0]        l2_tag_t;
  typedef logic [LINE_INDEX_BITS-1:0] l2_line_t;
  typedef logic [CACHE_LINE_BITS-1:0] cache_line_data_t;

  typedef enum logic [2:0] {
    L2REQ_LOAD        = 3'd0,
    L2REQ_STORE       = 3'd1,
    L2REQ_FLUSH       = 3'd2,
    L2REQ_DINVALIDATE = 3'd3,
    L2REQ_IINVALIDATE = 3'd4,
    L2REQ_LOAD_SYNC   = 3'd5,
    L2REQ_STORE_SYNC  = 3'd6
  } l2req_type_t;

  // address holds the cache line index, not the byte address
  typedef struct packed {
    logic        valid;
    l2req_type_t packet_type;
    l2_line_t    address;
  } l2req_packet_t;

  typedef struct packed {
    l2req_packet_t request;
    logic          dup;
  } miss_entry_t;

  typedef struct packed {
    logic [31:0]      address;
    cache_line_data_t data;
  } wb_entry_t;

  typedef enum logic [2:0] {
    StIdle,
    StWbAddr,
    StWbData,
    StRdAddr,
    StRdData,
    StRestart
  } bus_state_t;

  // Word idx of a line, word 0 being the most significant 32 bits
  function automatic logic [31:0] line_word(cache_line_data_t line, logic [3:0] idx);
    cache_line_data_t shifted;
    shifted = line << {idx, 5'b0};
    return shifted[CACHE_LINE_BITS-1 -: 32];
  endfunction

endpackage

// File: rtl/l2_bus_miss_engine_sync_fifo.sv
// Generic synchronous FIFO with a read-only view of every slot for associative lookups.
module l2_bus_miss_engine_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        free_count,
  output logic [DEPTH-1:0][WIDTH-1:0]   entries,
  output logic [DEPTH-1:0]              entry_valid
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] storage_q;
  logic [AW-1:0]               rd_ptr_q;
  logic [AW-1:0]               wr_ptr_q;
  logic [AW:0]                 count_q;

  assign head_data  = storage_q[rd_ptr_q];
  assign full       = (count_q == (AW+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign free_count = (AW+1)'(DEPTH) - count_q;
  assign entries    = storage_q;

  // Data slots carry no reset; occupancy is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (push) begin
      storage_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = ({1'b0, AW'(i) - rd_ptr_q} < count_q);
    end
  end

  // Overflow and underflow are upstream protocol errors
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && full));
      assert (!(pop && empty));
    end
  end

endmodule

// File: rtl/l2_bus_miss_engine.sv
// L2 back end: queues misses and dirty writebacks, runs line bursts on a 32-bit memory bus
// and hands completed fills back to the pipeline front as restarted requests.
module l2_bus_miss_engine
  import l2_bus_miss_engine_pkg::*;
#(
  parameter int unsigned MISS_DEPTH  = 8,
  parameter int unsigned WB_DEPTH    = 8,
  parameter int unsigned WAIT_MARGIN = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  l2req_packet_t              l2r_request,
  input  logic                       l2r_cache_hit,
  input  logic                       l2r_is_l2_fill,
  input  logic                       l2r_needs_writeback,
  input  l2_tag_t                    l2r_writeback_tag,
  input  logic [CACHE_LINE_BITS-1:0] l2r_data,
  output logic                       bif_input_wait,
  output logic                       bif_restart_valid,
  output l2req_packet_t              bif_restart_request,
  output logic [CACHE_LINE_BITS-1:0] bif_restart_data,
  output logic                       bif_restart_is_dup,
  input  logic                       bif_restart_ack,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic                       mem_req_write,
  output logic [31:0]                mem_req_addr,
  output logic                       mem_wvalid,
  input  logic                       mem_wready,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_rvalid,
  input  logic [31:0]                mem_rdata
);

  localparam int unsigned MISS_CW = $clog2(MISS_DEPTH) + 1;
  localparam int unsigned WB_CW   = $clog2(WB_DEPTH) + 1;
  localparam logic [MISS_CW-1:0] MISS_MARGIN = MISS_CW'(WAIT_MARGIN);
  localparam logic [WB_CW-1:0]   WB_MARGIN   = WB_CW'(WAIT_MARGIN);
  localparam logic [3:0]         LAST_BEAT   = 4'(BEATS_PER_LINE - 1);
  localparam int unsigned MISS_W = $bits(miss_entry_t);
  localparam int unsigned WB_W   = $bits(wb_entry_t);

  bus_state_t       state_q;
  logic [3:0]       beat_q;
  cache_line_data_t line_buf_q;

  logic        is_miss_type;
  logic        miss_push;
  logic        wb_push;
  logic        miss_pop;
  logic        wb_pop;
  logic        miss_dup;
  miss_entry_t miss_push_entry;
  wb_entry_t   wb_push_entry;
  miss_entry_t miss_head;
  wb_entry_t   wb_head;
  logic        miss_full;
  logic        miss_empty;
  logic        wb_full;
  logic        wb_empty;
  logic [MISS_CW-1:0]                  miss_free;
  logic [WB_CW-1:0]                    wb_free;
  logic [MISS_DEPTH-1:0][MISS_W-1:0]   miss_entries;
  logic [MISS_DEPTH-1:0]               miss_entry_valid;
  logic [WB_DEPTH-1:0][WB_W-1:0]       wb_entries;
  logic [WB_DEPTH-1:0]                 wb_entry_valid;
  logic                                unused_fifo_view;

  assign is_miss_type = l2r_request.packet_type inside
                        {L2REQ_LOAD, L2REQ_LOAD_SYNC, L2REQ_STORE, L2REQ_STORE_SYNC};
  assign miss_push = l2r_request.valid && !l2r_cache_hit && !l2r_is_l2_fill && is_miss_type;
  assign wb_push   = l2r_request.valid && l2r_needs_writeback &&
                     (l2r_is_l2_fill || (l2r_request.packet_type == L2REQ_FLUSH && l2r_cache_hit));

  assign miss_push_entry = '{request: l2r_request, dup: miss_dup};
  assign wb_push_entry   = '{address: {l2r_writeback_tag, l2r_request.address[SET_INDEX_BITS-1:0],
                                       {LINE_OFFSET_BITS{1'b0}}},
                             data:    l2r_data};

  assign wb_pop   = (state_q == StWbData) && mem_wvalid && mem_wready && (beat_q == LAST_BEAT);
  assign miss_pop = (state_q == StRestart) && bif_restart_valid && bif_restart_ack;

  assign bif_input_wait = (miss_free <= MISS_MARGIN) || (wb_free <= WB_MARGIN);

  assign unused_fifo_view = ^{wb_entries, wb_entry_valid, wb_full, miss_full};

  // Duplicate-line match against every live miss, including the head being served or popped
  always_comb begin
    miss_entry_t cmp_entry;
    cmp_entry = '0;
    miss_dup  = 1'b0;
    for (int i = 0; i < MISS_DEPTH; i++) begin
      cmp_entry = miss_entry_t'(miss_entries[i]);
      if (miss_entry_valid[i] && (cmp_entry.request.address == l2r_request.address)) begin
        miss_dup = 1'b1;
      end
    end
  end

  l2_bus_miss_engine_sync_fifo #(
    .WIDTH (MISS_W),
    .DEPTH (MISS_DEPTH)
  ) u_miss_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (miss_push),
    .push_data   (miss_push_entry),
    .pop         (miss_pop),
    .head_data   (miss_head),
    .full        (miss_full),
    .empty       (miss_empty),
    .free_count  (miss_free),
    .entries     (miss_entries),
    .entry_valid (miss_entry_valid)
  );

  l2_bus_miss_engine_sync_fifo #(
    .WIDTH (WB_W),
    .DEPTH (WB_DEPTH)
  ) u_wb_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (wb_push),
    .push_data   (wb_push_entry),
    .pop         (wb_pop),
    .head_data   (wb_head),
    .full        (wb_full),
    .empty       (wb_empty),
    .free_count  (wb_free),
    .entries     (wb_entries),
    .entry_valid (wb_entry_valid)
  );

  // Bus FSM with registered memory and restart outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= StIdle;
      beat_q              <= '0;
      line_buf_q          <= '0;
      mem_req_valid       <= 1'b0;
      mem_req_write       <= 1'b0;
      mem_req_addr        <= '0;
      mem_wvalid          <= 1'b0;
      mem_wdata           <= '0;
      bif_restart_valid   <= 1'b0;
      bif_restart_request <= '0;
      bif_restart_data    <= '0;
      bif_restart_is_dup  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Writebacks first so a later fill of the same line reads the written data
          if (!wb_empty) begin
            state_q       <= StWbAddr;
            mem_req_valid <= 1'b1;
            mem_req_write <= 1'b1;
            mem_req_addr  <= wb_head.address;
          end else if (!miss_empty) begin
            if (miss_head.dup) begin
              state_q             <= StRestart;
              bif_restart_valid   <= 1'b1;
              bif_restart_request <= miss_head.request;
              bif_restart_data    <= line_buf_q;
              bif_restart_is_dup  <= 1'b1;
            end else begin
              state_q       <= StRdAddr;
              mem_req_valid <= 1'b1;
              mem_req_write <= 1'b0;
              mem_req_addr  <= {miss_head.request.address, {LINE_OFFSET_BITS{1'b0}}};
            end
          end
        end
        StWbAddr: begin
          if (mem_req_ready) begin
            state_q       <= StWbData;
            mem_req_valid <= 1'b0;
            mem_wvalid    <= 1'b1;
            mem_wdata     <= line_word(wb_head.data, 4'd0);
            beat_q        <= '0;
          end
        end
        StWbData: begin
          if (mem_wvalid && mem_wready) begin
            if (beat_q == LAST_BEAT) begin
              state_q    <= StIdle;
              mem_wvalid <= 1'b0;
              beat_q     <= '0;
            end else begin
              beat_q    <= beat_q + 4'd1;
              mem_wdata <= line_word(wb_head.data, beat_q + 4'd1);
            end
          end
        end
        StRdAddr: begin
          if (mem_req_ready) begin
            state_q       <= StRdData;
            mem_req_valid <= 1'b0;
            beat_q        <= '0;
          end
        end
        StRdData: begin
          // Beats arrive MSW first and shift in from the bottom
          if (mem_rvalid) begin
            line_buf_q <= {line_buf_q[CACHE_LINE_BITS-33:0], mem_rdata};
            if (beat_q == LAST_BEAT) begin
              state_q             <= StRestart;
              beat_q              <= '0;
              bif_restart_valid   <= 1'b1;
              bif_restart_request <= miss_head.request;
              bif_restart_data    <= {line_buf_q[CACHE_LINE_BITS-33:0], mem_rdata};
              bif_restart_is_dup  <= 1'b0;
            end else begin
              beat_q <= beat_q + 4'd1;
            end
          end
        end
        StRestart: begin
          if (bif_restart_ack) begin
            state_q           <= StIdle;
            bif_restart_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_bus_miss_engine.sv
// Directed self-checking bench for l2_bus_miss_engine with a zero-wait memory responder.
module tb_l2_bus_miss_engine;
  import l2_bus_miss_engine_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  l2req_packet_t    l2r_request;
  logic             l2r_cache_hit;
  logic             l2r_is_l2_fill;
  logic             l2r_needs_writeback;
  l2_tag_t          l2r_writeback_tag;
  cache_line_data_t l2r_data;
  logic             bif_input_wait;
  logic             bif_restart_valid;
  l2req_packet_t    bif_restart_request;
  cache_line_data_t bif_restart_data;
  logic             bif_restart_is_dup;
  logic             bif_restart_ack;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic             mem_req_write;
  logic [31:0]      mem_req_addr;
  logic             mem_wvalid;
  logic             mem_wready;
  logic [31:0]      mem_wdata;
  logic             mem_rvalid;
  logic [31:0]      mem_rdata;

  int checks = 0;
  int errors = 0;

  // memory-side log
  int          cyc;
  int          rd_left;
  int          rd_word;
  logic [31:0] req_addr[$];
  logic        req_write[$];
  int          req_cyc[$];
  logic [31:0] wbeats[$];
  int          wbeat_cyc[$];

  always #5 clk = ~clk;

  l2_bus_miss_engine dut (
    .clk                 (clk),
    .reset               (reset),
    .l2r_request         (l2r_request),
    .l2r_cache_hit       (l2r_cache_hit),
    .l2r_is_l2_fill      (l2r_is_l2_fill),
    .l2r_needs_writeback (l2r_needs_writeback),
    .l2r_writeback_tag   (l2r_writeback_tag),
    .l2r_data            (l2r_data),
    .bif_input_wait      (bif_input_wait),
    .bif_restart_valid   (bif_restart_valid),
    .bif_restart_request (bif_restart_request),
    .bif_restart_data    (bif_restart_data),
    .bif_restart_is_dup  (bif_restart_is_dup),
    .bif_restart_ack     (bif_restart_ack),
    .mem_req_valid       (mem_req_valid),
    .mem_req_ready       (mem_req_ready),
    .mem_req_write       (mem_req_write),
    .mem_req_addr        (mem_req_addr),
    .mem_wvalid          (mem_wvalid),
    .mem_wready          (mem_wready),
    .mem_wdata           (mem_wdata),
    .mem_rvalid          (mem_rvalid),
    .mem_rdata           (mem_rdata)
  );

  // Zero-wait memory: logs handshakes at negedge, returns read words 0..15 after a read request
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    rd_left    = 0;
    rd_word    = 0;
    cyc        = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        rd_left = 0;
      end else begin
        if (mem_req_valid && mem_req_ready) begin
          req_addr.push_back(mem_req_addr);
          req_write.push_back(mem_req_write);
          req_cyc.push_back(cyc);
          if (!mem_req_write) begin
            rd_left = 16;
            rd_word = 0;
          end
        end
        if (mem_wvalid && mem_wready) begin
          wbeats.push_back(mem_wdata);
          wbeat_cyc.push_back(cyc);
        end
      end
      @(posedge clk);
      #1;
      if (rd_left > 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'(rd_word);
        rd_word++;
        rd_left--;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
    end
  end

  function automatic cache_line_data_t make_line(input logic [31:0] base);
    cache_line_data_t l;
    l = '0;
    for (int i = 0; i < 16; i++) l[CACHE_LINE_BITS-1-32*i -: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic idle_inputs();
    l2r_request         = '0;
    l2r_cache_hit       = 1'b0;
    l2r_is_l2_fill      = 1'b0;
    l2r_needs_writeback = 1'b0;
    l2r_writeback_tag   = '0;
    l2r_data            = '0;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bif_restart_ack = 1'b0;
    mem_req_ready   = 1'b1;
    mem_wready      = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    req_addr.delete();
    req_write.delete();
    req_cyc.delete();
    wbeats.delete();
    wbeat_cyc.delete();
  endtask

  task automatic issue(input l2req_type_t t, input l2_line_t line, input logic hit,
                       input logic fill, input logic nwb, input l2_tag_t tag,
                       input cache_line_data_t data);
    l2r_request         = '{valid: 1'b1, packet_type: t, address: line};
    l2r_cache_hit       = hit;
    l2r_is_l2_fill      = fill;
    l2r_needs_writeback = nwb;
    l2r_writeback_tag   = tag;
    l2r_data            = data;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic wait_restart(input int budget, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (n < budget && !ok) begin
      @(posedge clk); #1;
      n++;
      if (bif_restart_valid) ok = 1'b1;
    end
  endtask

  task automatic pulse_ack();
    bif_restart_ack = 1'b1;
    @(posedge clk); #1;
    bif_restart_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bif_restart_ack = 1'b0;
    mem_req_ready = 1'b1;
    mem_wready = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    checks++;
    if ({mem_req_valid, mem_req_write, mem_req_addr, mem_wvalid, mem_wdata, bif_restart_valid,
         bif_restart_is_dup, bif_input_wait} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got req_v=%b wr=%b addr=%h wv=%b wd=%h rv=%b dup=%b wait=%b, need all 0",
               mem_req_valid, mem_req_write, mem_req_addr, mem_wvalid, mem_wdata,
               bif_restart_valid, bif_restart_is_dup, bif_input_wait);
    end
    checks++;
    if (bif_restart_request !== '0 || bif_restart_data !== '0) begin
      errors++;
      $display("FAIL reset_restart_bus: got req=%h data_or=%b, need 0",
               bif_restart_request, |bif_restart_data);
    end
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (mem_req_valid !== 1'b0 || bif_input_wait !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got req_v=%b wait=%b, need 0 0", mem_req_valid, bif_input_wait);
    end
  endtask

  task automatic test_single_miss();
    int n;
    bit ok;
    do_reset();
    issue(L2REQ_LOAD, 26'h100, 1'b0, 1'b0, 1'b0, '0, '0);
    wait_restart(40, n, ok);
    checks++;
    if (!ok || n + 1 != 19) begin
      errors++;
      $display("FAIL miss_latency: got ok=%b latency=%0d, need 19", ok, n + 1);
    end
    checks++;
    if (bif_restart_data !== make_line(32'd0)) begin
      errors++;
      $display("FAIL miss_data: got msw=%h lsw=%h, need msw=0 lsw=f",
               bif_restart_data[511:480], bif_restart_data[31:0]);
    end
    checks++;
    if (bif_restart_is_dup !== 1'b0 || bif_restart_request.address !== 26'h100 ||
        bif_restart_request.packet_type !== L2REQ_LOAD) begin
      errors++;
      $display("FAIL miss_request: got dup=%b line=%h type=%0d, need 0 100 0",
               bif_restart_is_dup, bif_restart_request.address, bif_restart_request.packet_type);
    end
    checks++;
    if (req_addr.size() != 1 || req_addr[0] !== 32'h4000 || req_write[0] !== 1'b0) begin
      errors++;
      $display("FAIL miss_bus_req: got count=%0d addr=%h wr=%b, need 1 00004000 0",
               req_addr.size(), req_addr[0], req_write[0]);
    end
    pulse_ack();
    checks++;
    if (bif_restart_valid !== 1'b0) begin
      errors++;
      $display("FAIL miss_ack_clear: got valid=%b, need 0", bif_restart_valid);
    end
  endtask

  task automatic test_writeback();
    int n;
    bit ok;
    cache_line_data_t wl;
    wl = make_line(32'hA500_0000);
    do_reset();
    // fill of line {tag 5, set 200} evicting a dirty victim with tag 0 -> byte addr 0x8000
    issue(L2REQ_LOAD, {16'h0005, 10'h200}, 1'b0, 1'b1, 1'b1, 16'h0000, wl);
    issue(L2REQ_LOAD, 26'h123, 1'b0, 1'b0, 1'b0, '0, '0);
    wait_restart(80, n, ok);
    checks++;
    if (!ok || bif_restart_request.address !== 26'h123) begin
      errors++;
      $display("FAIL wb_restart: got ok=%b line=%h, need 1 123", ok, bif_restart_request.address);
    end
    checks++;
    if (req_addr.size() != 2 || req_addr[0] !== 32'h8000 || req_write[0] !== 1'b1 ||
        req_addr[1] !== 32'h48C0 || req_write[1] !== 1'b0) begin
      errors++;
      $display("FAIL wb_bus_reqs: got n=%0d a0=%h w0=%b a1=%h w1=%b, need 2 8000 1 48c0 0",
               req_addr.size(), req_addr[0], req_write[0], req_addr[1], req_write[1]);
    end
    checks++;
    if (wbeats.size() != 16) begin
      errors++;
      $display("FAIL wb_beat_count: got %0d, need 16", wbeats.size());
    end
    for (int i = 0; i < 16 && i < wbeats.size(); i++) begin
      checks++;
      if (wbeats[i] !== 32'hA500_0000 + 32'(i)) begin
        errors++;
        $display("FAIL wb_beat%0d: got %h, need %h", i, wbeats[i], 32'hA500_0000 + 32'(i));
      end
    end
    if (wbeats.size() == 16 && req_cyc.size() == 2) begin
      checks++;
      if (req_cyc[1] <= wbeat_cyc[15]) begin
        errors++;
        $display("FAIL wb_order: got read req cycle %0d, need after last beat cycle %0d",
                 req_cyc[1], wbeat_cyc[15]);
      end
    end
    pulse_ack();
  endtask

  task automatic test_back_to_back_dup();
    int n;
    bit ok;
    do_reset();
    issue(L2REQ_STORE, 26'h0AB, 1'b0, 1'b0, 1'b0, '0, '0);
    issue(L2REQ_LOAD, 26'h0AB, 1'b0, 1'b0, 1'b0, '0, '0);
    wait_restart(40, n, ok);
    checks++;
    if (!ok || bif_restart_is_dup !== 1'b0 || bif_restart_request.packet_type !== L2REQ_STORE) begin
      errors++;
      $display("FAIL dup_first: got ok=%b dup=%b type=%0d, need 1 0 1",
               ok, bif_restart_is_dup, bif_restart_request.packet_type);
    end
    pulse_ack();
    wait_restart(5, n, ok);
    checks++;
    if (!ok || bif_restart_is_dup !== 1'b1 || bif_restart_request.address !== 26'h0AB ||
        bif_restart_request.packet_type !== L2REQ_LOAD) begin
      errors++;
      $display("FAIL dup_second: got ok=%b dup=%b line=%h type=%0d, need 1 1 0ab 0",
               ok, bif_restart_is_dup, bif_restart_request.address,
               bif_restart_request.packet_type);
    end
    checks++;
    if (req_addr.size() != 1) begin
      errors++;
      $display("FAIL dup_reads: got %0d memory requests, need 1", req_addr.size());
    end
    pulse_ack();
  endtask

  task automatic test_stall();
    int n;
    bit ok;
    do_reset();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(L2REQ_LOAD, 26'h10 + 26'(i), 1'b0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (bif_input_wait !== 1'b0) begin
      errors++;
      $display("FAIL stall_four: got wait=%b, need 0", bif_input_wait);
    end
    issue(L2REQ_LOAD_SYNC, 26'h14, 1'b0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (bif_input_wait !== 1'b1) begin
      errors++;
      $display("FAIL stall_five: got wait=%b, need 1", bif_input_wait);
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0 || mem_req_addr !== 32'h400) begin
      errors++;
      $display("FAIL stall_req_hold: got v=%b wr=%b addr=%h, need 1 0 00000400",
               mem_req_valid, mem_req_write, mem_req_addr);
    end
    mem_req_ready = 1'b1;
    wait_restart(40, n, ok);
    checks++;
    if (!ok || bif_input_wait !== 1'b1) begin
      errors++;
      $display("FAIL stall_before_pop: got ok=%b wait=%b, need 1 1", ok, bif_input_wait);
    end
    pulse_ack();
    checks++;
    if (bif_input_wait !== 1'b0) begin
      errors++;
      $display("FAIL stall_after_pop: got wait=%b, need 0", bif_input_wait);
    end
  endtask

  task automatic test_ack_hold();
    int n;
    bit ok;
    l2req_packet_t    s_req;
    cache_line_data_t s_data;
    logic             s_dup;
    do_reset();
    issue(L2REQ_LOAD, 26'h2A0, 1'b0, 1'b0, 1'b0, '0, '0);
    issue(L2REQ_STORE_SYNC, 26'h2A1, 1'b0, 1'b0, 1'b0, '0, '0);
    wait_restart(40, n, ok);
    s_req  = bif_restart_request;
    s_data = bif_restart_data;
    s_dup  = bif_restart_is_dup;
    checks++;
    if (!ok || s_req.address !== 26'h2A0) begin
      errors++;
      $display("FAIL hold_first: got ok=%b line=%h, need 1 2a0", ok, s_req.address);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bif_restart_valid !== 1'b1 || bif_restart_request !== s_req ||
          bif_restart_data !== s_data || bif_restart_is_dup !== s_dup || mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: got valid=%b req=%h dup=%b req_v=%b, need 1 %h %b 0",
                 i, bif_restart_valid, bif_restart_request, bif_restart_is_dup, mem_req_valid,
                 s_req, s_dup);
      end
    end
    pulse_ack();
    checks++;
    if (bif_restart_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_ack_clear: got valid=%b, need 0", bif_restart_valid);
    end
    wait_restart(40, n, ok);
    checks++;
    if (!ok || bif_restart_request.address !== 26'h2A1 || req_addr.size() != 2) begin
      errors++;
      $display("FAIL hold_second: got ok=%b line=%h reqs=%0d, need 1 2a1 2",
               ok, bif_restart_request.address, req_addr.size());
    end
    pulse_ack();
    repeat (20) begin @(posedge clk); #1; end
    checks++;
    if (req_addr.size() != 2 || bif_restart_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_drained: got reqs=%0d valid=%b, need 2 0", req_addr.size(),
               bif_restart_valid);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    n = 0;
    do_reset();
    // dirty flush hit: tag c3, set 055 -> byte addr 0x00C31540
    issue(L2REQ_FLUSH, {16'h1234, 10'h055}, 1'b1, 1'b0, 1'b1, 16'h00C3, make_line(32'h5A00_0000));
    while (wbeats.size() < 7 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (wbeats.size() != 7 || mem_wdata !== 32'h5A00_0007 || req_addr[0] !== 32'h00C3_1540) begin
      errors++;
      $display("FAIL midburst_beat7: got beats=%0d wdata=%h addr=%h, need 7 5a000007 00c31540",
               wbeats.size(), mem_wdata, req_addr[0]);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({mem_req_valid, mem_req_write, mem_req_addr, mem_wvalid, mem_wdata, bif_restart_valid,
         bif_restart_is_dup, bif_input_wait} !== '0 ||
        bif_restart_request !== '0 || bif_restart_data !== '0) begin
      errors++;
      $display("FAIL midburst_reset: got req_v=%b addr=%h wv=%b wd=%h rv=%b wait=%b, need all 0",
               mem_req_valid, mem_req_addr, mem_wvalid, mem_wdata, bif_restart_valid,
               bif_input_wait);
    end
    reset = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    checks++;
    if (mem_req_valid !== 1'b0 || mem_wvalid !== 1'b0 || bif_restart_valid !== 1'b0) begin
      errors++;
      $display("FAIL midburst_idle: got req_v=%b wv=%b rv=%b, need 0 0 0",
               mem_req_valid, mem_wvalid, bif_restart_valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    bif_restart_ack = 1'b0;
    mem_req_ready = 1'b1;
    mem_wready = 1'b1;
    idle_inputs();
    test_reset();
    test_single_miss();
    test_writeback();
    test_back_to_back_dup();
    test_stall();
    test_ack_hold();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
